// File: rtl/reg_status_file.sv
// reg_status_file: architectural register file with per-register ROB reference tracking
//
// Ports:
//   clk, rst                        clock; synchronous active-low reset
//   read_en_N, read_addr_N          operand read request, N = 1,2 (combinational)
//   read_is_ref_N, read_data_N      1: data is a zero-extended ROB tag; 0: committed value
//   alloc_en/alloc_addr/alloc_tag   dispatch claims a destination for a ROB tag
//   commit_en/_addr/_tag/_data      ROB retires a result and releases a matching claim
//   flush                           drops every outstanding reference
//   ref_count                       registered number of registers holding a reference
// Optional: define REG_STATUS_BYPASS_EN for same-cycle commit-to-read forwarding.
module reg_status_file #(
  parameter int ROB_ADDR_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      read_en_1,
  input  logic [4:0]                read_addr_1,
  output logic                      read_is_ref_1,
  output logic [31:0]               read_data_1,
  input  logic                      read_en_2,
  input  logic [4:0]                read_addr_2,
  output logic                      read_is_ref_2,
  output logic [31:0]               read_data_2,
  input  logic                      alloc_en,
  input  logic [4:0]                alloc_addr,
  input  logic [ROB_ADDR_WIDTH-1:0] alloc_tag,
  input  logic                      commit_en,
  input  logic [4:0]                commit_addr,
  input  logic [ROB_ADDR_WIDTH-1:0] commit_tag,
  input  logic [31:0]               commit_data,
  input  logic                      flush,
  output logic [5:0]                ref_count
);
  logic [31:0][31:0]               data_q, data_d;
  logic [31:0]                     ref_valid_q, ref_valid_d;
  logic [31:0][ROB_ADDR_WIDTH-1:0] ref_tag_q, ref_tag_d;
  logic [5:0]                      count_q, count_d;
  logic                            commit_ok, alloc_ok, commit_match;
  assign commit_ok    = commit_en && commit_addr != 5'd0;
  assign alloc_ok     = alloc_en && alloc_addr != 5'd0 && !flush;
  assign commit_match = ref_valid_q[commit_addr] && ref_tag_q[commit_addr] == commit_tag;
  // Commit is applied first so a same-cycle alloc to the same register wins the reference.
  always_comb begin
    data_d      = data_q;
    ref_valid_d = ref_valid_q;
    ref_tag_d   = ref_tag_q;
    if (commit_ok) begin
      data_d[commit_addr] = commit_data;
      if (commit_match) ref_valid_d[commit_addr] = 1'b0;
    end
    if (flush) ref_valid_d = '0;
    if (alloc_ok) begin
      ref_valid_d[alloc_addr] = 1'b1;
      ref_tag_d[alloc_addr]   = alloc_tag;
    end
    count_d = '0;
    for (int i = 1; i < 32; i++) count_d = count_d + 6'(ref_valid_d[i]);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_q      <= '0;
      ref_valid_q <= '0;
      ref_tag_q   <= '0;
      count_q     <= '0;
    end else begin
      data_q      <= data_d;
      ref_valid_q <= ref_valid_d;
      ref_tag_q   <= ref_tag_d;
      count_q     <= count_d;
    end
  end
  assign ref_count = count_q;
  // Returns {is_ref, data}; r0 and disabled ports read as zero, as does everything in reset.
  function automatic logic [32:0] read_port(input logic en, input logic [4:0] a);
    logic bypass;
`ifdef REG_STATUS_BYPASS_EN
    bypass = commit_en && commit_addr == a && ref_valid_q[a] && ref_tag_q[a] == commit_tag;
`else
    bypass = 1'b0;
`endif
    return (!rst || !en || a == 5'd0) ? 33'd0 :
           bypass                     ? {1'b0, commit_data} :
           ref_valid_q[a]             ? {1'b1, 32'(ref_tag_q[a])} :
                                        {1'b0, data_q[a]};
  endfunction
  always_comb begin
    {read_is_ref_1, read_data_1} = read_port(read_en_1, read_addr_1);
    {read_is_ref_2, read_data_2} = read_port(read_en_2, read_addr_2);
  end
endmodule

// File: tb/tb_reg_status_file.sv
// tb_reg_status_file: directed table-driven checks of reg_status_file
module tb_reg_status_file;
`ifdef REG_STATUS_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst;
  logic        read_en_1, read_en_2, read_is_ref_1, read_is_ref_2;
  logic [4:0]  read_addr_1, read_addr_2, alloc_addr, commit_addr;
  logic [31:0] read_data_1, read_data_2, commit_data;
  logic        alloc_en, commit_en, flush;
  logic [3:0]  alloc_tag, commit_tag;
  logic [5:0]  ref_count;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  reg_status_file #(.ROB_ADDR_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .read_en_1(read_en_1), .read_addr_1(read_addr_1),
    .read_is_ref_1(read_is_ref_1), .read_data_1(read_data_1),
    .read_en_2(read_en_2), .read_addr_2(read_addr_2),
    .read_is_ref_2(read_is_ref_2), .read_data_2(read_data_2),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .alloc_tag(alloc_tag),
    .commit_en(commit_en), .commit_addr(commit_addr), .commit_tag(commit_tag),
    .commit_data(commit_data), .flush(flush), .ref_count(ref_count)
  );
  typedef struct {
    logic        rst;
    logic        re1;
    logic [4:0]  ra1;
    logic        re2;
    logic [4:0]  ra2;
    logic        ae;
    logic [4:0]  aa;
    logic [3:0]  at;
    logic        ce;
    logic [4:0]  ca;
    logic [3:0]  ct;
    logic [31:0] cd;
    logic        fl;
    logic        x_ref1;
    logic [31:0] x_d1;
    logic        x_ref2;
    logic [31:0] x_d2;
    logic [5:0]  x_cnt;
  } vec_t;
  vec_t v [20];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(input vec_t t);
    rst = t.rst; read_en_1 = t.re1; read_addr_1 = t.ra1; read_en_2 = t.re2; read_addr_2 = t.ra2;
    alloc_en = t.ae; alloc_addr = t.aa; alloc_tag = t.at;
    commit_en = t.ce; commit_addr = t.ca; commit_tag = t.ct; commit_data = t.cd; flush = t.fl;
  endtask
  initial begin
    //       rst re1 ra1 re2 ra2 ae aa at ce ca ct cd         fl  ref1 d1          ref2 d2    cnt
    v[0]  = '{0, 1, 5,  1, 5,  1, 5, 1, 0, 0, 0, 0,          0,  0, 0,           0, 0,     0};
    v[1]  = '{0, 1, 5,  1, 5,  1, 5, 1, 0, 0, 0, 0,          0,  0, 0,           0, 0,     0};
    v[2]  = '{1, 1, 5,  1, 5,  0, 0, 0, 0, 0, 0, 0,          0,  0, 0,           0, 0,     0};
    v[3]  = '{1, 1, 3,  1, 0,  1, 3, 7, 0, 0, 0, 0,          0,  0, 0,           0, 0,     0};
    v[4]  = '{1, 1, 3,  0, 3,  0, 0, 0, 0, 0, 0, 0,          0,  1, 32'h7,       0, 0,     1};
    v[5]  = '{1, 1, 4,  0, 0,  1, 4, 2, 0, 0, 0, 0,          0,  0, 0,           0, 0,     1};
    v[6]  = '{1, 1, 4,  0, 0,  1, 4, 9, 0, 0, 0, 0,          0,  1, 32'h2,       0, 0,     2};
    v[7]  = '{1, 1, 4,  0, 0,  0, 0, 0, 1, 4, 2, 32'hDEAD,   0,  1, 32'h9,       0, 0,     2};
    v[8]  = '{1, 1, 3,  0, 4,  0, 0, 0, 1, 4, 9, 32'hBEEF,   0,  1, 32'h7,       0, 0,     2};
    v[9]  = '{1, 1, 4,  1, 3,  0, 0, 0, 0, 0, 0, 0,          0,  0, 32'hBEEF,    1, 32'h7, 1};
    v[10] = '{1, 1, 4,  1, 6,  1, 6, 3, 1, 6, 1, 32'h55,     0,  0, 32'hBEEF,    0, 0,     1};
    v[11] = '{1, 1, 6,  1, 3,  0, 0, 0, 0, 0, 0, 0,          1,  1, 32'h3,       1, 32'h7, 2};
    v[12] = '{1, 1, 6,  1, 3,  1, 0, 5, 1, 0, 0, 32'h1234,   0,  0, 32'h55,      0, 0,     0};
    v[13] = '{1, 1, 0,  1, 0,  1, 9, 5, 1, 10, 0, 32'h77,    1,  0, 0,           0, 0,     0};
    v[14] = '{1, 1, 9,  1, 10, 0, 0, 0, 0, 0, 0, 0,          0,  0, 0,           0, 32'h77, 0};
    v[15] = '{1, 1, 8,  1, 8,  1, 8, 4, 0, 0, 0, 0,          0,  0, 0,           0, 0,     0};
    v[16] = '{1, 1, 8,  1, 8,  0, 0, 0, 1, 8, 4, 32'hCAFE,   0,  !BYP, BYP ? 32'hCAFE : 32'h4,
                                                                 !BYP, BYP ? 32'hCAFE : 32'h4, 1};
    v[17] = '{1, 1, 8,  1, 6,  0, 0, 0, 0, 0, 0, 0,          0,  0, 32'hCAFE,    0, 32'h55, 0};
    v[18] = '{0, 1, 8,  1, 6,  1, 5, 1, 1, 8, 0, 32'h99,     0,  0, 0,           0, 0,     0};
    v[19] = '{1, 1, 8,  1, 5,  0, 0, 0, 0, 0, 0, 0,          0,  0, 0,           0, 0,     0};
    drive(v[0]);
    @(posedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(v[i]);
      #1;
      chk($sformatf("row%0d ref1", i), 32'(read_is_ref_1), 32'(v[i].x_ref1));
      chk($sformatf("row%0d data1", i), read_data_1, v[i].x_d1);
      chk($sformatf("row%0d ref2", i), 32'(read_is_ref_2), 32'(v[i].x_ref2));
      chk($sformatf("row%0d data2", i), read_data_2, v[i].x_d2);
      chk($sformatf("row%0d count", i), 32'(ref_count), 32'(v[i].x_cnt));
    end
    for (int r = 1; r < 32; r++) begin
      @(negedge clk);
      drive('{1, 0, 0, 0, 0, 1, 5'(r), 4'(r), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    end
    @(negedge clk);
    alloc_en = 1'b0; read_en_1 = 1'b1; read_addr_1 = 5'd17;
    #1;
    chk("full count", 32'(ref_count), 32'd31);
    chk("full ref17", 32'(read_is_ref_1), 32'd1);
    chk("full tag17", read_data_1, 32'h1);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush count", 32'(ref_count), 32'd0);
    chk("flush ref17", 32'(read_is_ref_1), 32'd0);
    chk("flush data17", read_data_1, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reg_status_file.md
# reg_status_file

Architectural register file with per-register in-flight reference tracking for the out-of-order core. It answers the ID-stage operand reads (read enable/address) with either committed data or the reorder-buffer tag of the pending producer. Dispatch claims destination registers for ROB tags. Commit retires results into the file and releases the claim.

## Interface
- ROB_ADDR_WIDTH, 4, width of reorder-buffer tag; references are ROB indices.
- clk  input  1  core clock, all state updated on rising edge.
- rst  input  1  reset; synchronous, active-low.
- read_en_1  input  1  read port 1 enable.
- read_addr_1  input  5  read port 1 register index.
- read_is_ref_1  output  1  1: read_data_1 holds a ROB tag (zero-extended); 0: holds committed value.
- read_data_1  output  32  value or tag for port 1.
- read_en_2, read_addr_2, read_is_ref_2, read_data_2: same as port 1, for port 2.
- alloc_en  input  1  dispatch claims a destination register.
- alloc_addr  input  5  destination register index.
- alloc_tag  input  ROB_ADDR_WIDTH  ROB tag of producing instruction.
- commit_en  input  1  ROB retires a register-writing instruction.
- commit_addr  input  5  retired destination index.
- commit_tag  input  ROB_ADDR_WIDTH  retired ROB tag.
- commit_data  input  32  retired result.
- flush  input  1  pipeline flush (exception/mispredict); drops all references.
- ref_count  output  6  number of registers currently holding a reference (0..31).

## Operation
- State per register r (1..31): data[r] (32 b), ref_valid[r], ref_tag[r]. Register 0 has no storage: always reads data 0, is_ref 0; alloc/commit to r0 ignored.
- Read (combinational): en=0 → is_ref 0, data 0. Otherwise, if ref_valid[a] → is_ref 1, data = {zeros, ref_tag[a]}; else is_ref 0, data = data[a].
- Read sees pre-edge state for alloc in the same cycle: the instruction being dispatched reads its sources before its own destination claim takes effect.
- Alloc (edge): alloc_en and addr≠0 → ref_valid=1, ref_tag=alloc_tag, overwriting any older reference.
- Commit (edge): commit_en and addr≠0 → data[addr]=commit_data always. ref_valid cleared only if ref_valid and ref_tag==commit_tag; a mismatch means a younger claim exists, so the reference is kept.
- Simultaneous alloc and commit, same register: data written, alloc wins (ref_valid=1, ref_tag=alloc_tag).
- Flush (edge): all ref_valid cleared. A commit in the same cycle still writes data. An alloc in the same cycle is discarded.
- ref_count: registered popcount of ref_valid after each update.

## Timing
- Reset (rst=0 at edge): all data 0, all ref_valid 0, ref_tag 0, ref_count 0. Read outputs are 0 while rst=0, regardless of read_en. Reset overrides alloc/commit/flush.
- Alloc/commit/flush take effect at the clock edge and are visible to reads in the following cycle, except the bypass below.
- Read-to-output latency: 0 cycles (combinational).
- No back-pressure; every asserted alloc/commit is accepted in that cycle.

## Configuration
- REG_STATUS_BYPASS_EN defined: same-cycle commit-to-read forwarding applies when commit_en is set, the address matches, addr≠0, ref_valid is set and ref_tag==commit_tag. The read then returns is_ref 0 with data=commit_data. This bypass applies to both ports.
- Undefined: reads reflect registered state only. The ROB must keep the committed entry's result readable for one cycle after retirement.

## Test plan
- Reset: hold rst=0 two cycles with alloc_en=1, addr 5 → after release, read r5 returns is_ref 0, data 0; ref_count 0.
- Alloc then read: alloc r3 tag 7; next cycle read port 1 r3 → is_ref 1, data 0x7; ref_count 1.
- Commit matching vs stale: alloc r4 tag 2, then alloc r4 tag 9, then commit r4 tag 2 data 0xDEAD → r4 still is_ref 1 tag 9. Commit r4 tag 9 data 0xBEEF → is_ref 0, data 0xBEEF.
- Same-cycle alloc+commit r6 (alloc tag 3, commit tag 1 data 0x55) → next read r6 is_ref 1 tag 3. Then flush → is_ref 0, data 0x55.
- r0: alloc r0 tag 5, commit r0 data 0x1234 → read r0 is_ref 0, data 0; ref_count unchanged.
- Bypass (macro defined): r8 ref tag 4; same cycle commit r8 tag 4 data 0xCAFE and read r8 → is_ref 0, data 0xCAFE. Without macro → is_ref 1, data 0x4.
